// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared types and defaults for the data-memory arbiter.
//           arb_state_t - arbiter sequencing state
//           arb_owner_t - which requester owns the outstanding read
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_RET  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_EXT  = 1'b1
    } arb_owner_t;

    localparam int DATA_W_DEF = 24;

endpackage

`default_nettype wire

// File: rtl/mem_rd_latency_counter.sv
// ============================================================================
// Module  : mem_rd_latency_counter
// Purpose : Read-latency timer. Loaded with RD_LAT in the read issue cycle,
//           counts down once per cycle and flags the cycle in which the
//           count reaches zero, i.e. the cycle RD_LAT after the load.
// Ports   : clk     - clock, rising edge
//           rst     - asynchronous reset, active-high
//           i_load  - read issued this cycle, restart the count
//           o_done  - memory read data is valid this cycle
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_rd_latency_counter #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_done
);

    localparam int c_CNT_W = $clog2(RD_LAT + 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_CNT_W'(RD_LAT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    // Done in the cycle whose decrement lands on zero.
    assign o_done = (r_cnt == c_CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// Module  : data_mem_arbiter
// Purpose : Shares the single-port data memory between the pipeline MEM
//           stage and an external loader (DMA / image load) port. Issues
//           writes in a single cycle, sequences multi-cycle reads, returns
//           read data to the owning requester and stalls the pipeline while
//           its access is pending or blocked. One access outstanding at most.
// Ports   : clk, rst                  - clock / async active-high reset
//           i_pipe_re/we/addr/wdata   - MEM-stage request
//           o_pipe_rdata/rvalid       - load data to MEM/WB
//           o_pipe_stall              - freeze IF..EX/MEM registers
//           i_ext_req/we/addr/wdata   - loader request (held until grant)
//           o_ext_gnt                 - loader issue-cycle pulse
//           o_ext_rdata/rvalid        - loader read data
//           o_mem_addr/wdata/we/re    - memory macro control
//           i_mem_rdata               - memory data, RD_LAT after mem_re
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pipe_re,
    input  logic              i_pipe_we,
    input  logic [DATA_W-1:0] i_pipe_addr,
    input  logic [DATA_W-1:0] i_pipe_wdata,
    output logic [DATA_W-1:0] o_pipe_rdata,
    output logic              o_pipe_rvalid,
    output logic              o_pipe_stall,
    input  logic              i_ext_req,
    input  logic              i_ext_we,
    input  logic [DATA_W-1:0] i_ext_addr,
    input  logic [DATA_W-1:0] i_ext_wdata,
    output logic              o_ext_gnt,
    output logic [DATA_W-1:0] o_ext_rdata,
    output logic              o_ext_rvalid,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_t              r_state;
    arb_owner_t              r_owner;
    logic [c_STARVE_W-1:0]   r_starve;
    logic [DATA_W-1:0]       r_pipe_rdata;
    logic [DATA_W-1:0]       r_ext_rdata;

    logic w_pipe_req;
    logic w_arb_slot;
    logic w_ret_pipe;
    logic w_starved;
    logic w_ext_win;
    logic w_pipe_win;
    logic w_pipe_rd;
    logic w_ext_rd;
    logic w_issue_rd;
    logic w_cnt_done;

    assign w_pipe_req = i_pipe_re | i_pipe_we;
    assign w_arb_slot = (r_state == IDLE) || (r_state == RD_RET);
    assign w_starved  = (r_starve == c_STARVE_W'(STARVE_MAX));

    // In RD_RET(PIPE) the pipe's request lines still belong to the load that
    // is completing this cycle; it must not re-issue, but it still counts as
    // a requester so the loader only gets in when it is starved.
    assign w_ret_pipe = (r_state == RD_RET) && (r_owner == OWN_PIPE);

    assign w_ext_win  = !rst && w_arb_slot && i_ext_req && (!w_pipe_req || w_starved);
    assign w_pipe_win = !rst && w_arb_slot && !w_ret_pipe && !w_ext_win && w_pipe_req;

    // Write takes priority when both enables are set; the read is dropped.
    assign w_pipe_rd  = w_pipe_win && !i_pipe_we;
    assign w_ext_rd   = w_ext_win && !i_ext_we;
    assign w_issue_rd = w_pipe_rd || w_ext_rd;

    mem_rd_latency_counter #(
        .RD_LAT (RD_LAT)
    ) u_lat_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_issue_rd),
        .o_done (w_cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_PIPE;
            r_starve     <= '0;
            r_pipe_rdata <= '0;
            r_ext_rdata  <= '0;
        end else begin
            if (!i_ext_req || w_ext_win) begin
                r_starve <= '0;
            end else if (w_pipe_win && !w_starved) begin
                r_starve <= r_starve + c_STARVE_W'(1);
            end

            case (r_state)
                IDLE, RD_RET: begin
                    if (w_issue_rd) begin
                        r_state <= RD_WAIT;
                        r_owner <= w_ext_rd ? OWN_EXT : OWN_PIPE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (w_cnt_done) begin
                        r_state <= RD_RET;
                        if (r_owner == OWN_PIPE) begin
                            r_pipe_rdata <= i_mem_rdata;
                        end else begin
                            r_ext_rdata <= i_mem_rdata;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_mem_re    = w_issue_rd;
    assign o_mem_we    = (w_pipe_win && i_pipe_we) || (w_ext_win && i_ext_we);
    assign o_mem_addr  = w_ext_win ? i_ext_addr  : (w_pipe_win ? i_pipe_addr  : '0);
    assign o_mem_wdata = w_ext_win ? i_ext_wdata : (w_pipe_win ? i_pipe_wdata : '0);
    assign o_ext_gnt   = w_ext_win;

    // Stall whenever the pipe's access cannot complete this cycle.
    assign o_pipe_stall = !rst && w_pipe_req && !w_ret_pipe &&
                          ((r_state == RD_WAIT) || w_ext_win || w_pipe_rd);

    assign o_pipe_rvalid = w_ret_pipe;
    assign o_ext_rvalid  = (r_state == RD_RET) && (r_owner == OWN_EXT);
    assign o_pipe_rdata  = r_pipe_rdata;
    assign o_ext_rdata   = r_ext_rdata;

endmodule

`default_nettype wire
